// File: rtl/fetch_pc_unit_if.sv
// Decode/CP0-to-fetch bundle for fetch_pc_unit. The master drives the redirect
// controls; the slave (the PC unit) returns the fetch address and flags.
interface fetch_pc_unit_if;
  logic        stall;
  logic        isBranch;
  logic [9:0]  D_inStrType;
  logic [31:0] D_PC;
  logic [15:0] D_imm16;
  logic [25:0] D_index26;
  logic [31:0] D_RD1;
  logic        req;
  logic [31:0] EPC;
  logic [31:0] F_PC;
  logic        F_BD;
  logic        F_ExcAdEL;

  modport master (
    output stall, isBranch, D_inStrType, D_PC, D_imm16, D_index26, D_RD1, req, EPC,
    input  F_PC, F_BD, F_ExcAdEL
  );

  modport slave (
    input  stall, isBranch, D_inStrType, D_PC, D_imm16, D_index26, D_RD1, req, EPC,
    output F_PC, F_BD, F_ExcAdEL
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with prioritised next-PC selection (exception, eret, stall,
// branch, jump, jr, sequential). Optional fetch address check: FETCH_ADEL_CHECK_EN.
module fetch_pc_unit (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_unit_if.slave bus
);

  // Decode-stage instruction type codes; must match the decoder's table.
  localparam logic [9:0] INSTR_BEQ  = 10'h001;
  localparam logic [9:0] INSTR_BNE  = 10'h002;
  localparam logic [9:0] INSTR_J    = 10'h004;
  localparam logic [9:0] INSTR_JAL  = 10'h008;
  localparam logic [9:0] INSTR_JR   = 10'h010;
  localparam logic [9:0] INSTR_ERET = 10'h020;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR,
    SEL_SEQ
  } next_sel_e;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  next_sel_e   next_sel;

  logic        is_branch_instr;
  logic        is_jump_instr;
  logic        is_jr_instr;
  logic        is_eret_instr;
  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] seq_pc;

  assign is_branch_instr = (bus.D_inStrType == INSTR_BEQ) || (bus.D_inStrType == INSTR_BNE);
  assign is_jump_instr   = (bus.D_inStrType == INSTR_J)   || (bus.D_inStrType == INSTR_JAL);
  assign is_jr_instr     = (bus.D_inStrType == INSTR_JR);
  assign is_eret_instr   = (bus.D_inStrType == INSTR_ERET);

  // All target arithmetic is 32-bit and wraps silently.
  assign branch_off = {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};
  assign branch_tgt = bus.D_PC + 32'd4 + branch_off;
  assign jump_tgt   = {bus.D_PC[31:28], bus.D_index26, 2'b00};
  assign seq_pc     = pc_q + 32'd4;

  always_comb begin
    next_sel = SEL_SEQ;
    if (bus.req) begin
      next_sel = SEL_EXC;
    end else if (is_eret_instr) begin
      next_sel = SEL_ERET;
    end else if (bus.stall) begin
      next_sel = SEL_HOLD;
    end else if (is_branch_instr && bus.isBranch) begin
      next_sel = SEL_BRANCH;
    end else if (is_jump_instr) begin
      next_sel = SEL_JUMP;
    end else if (is_jr_instr) begin
      next_sel = SEL_JR;
    end
  end

  always_comb begin
    pc_d = seq_pc;
    case (next_sel)
      SEL_EXC:    pc_d = EXC_PC;
      SEL_ERET:   pc_d = bus.EPC;
      SEL_HOLD:   pc_d = pc_q;
      SEL_BRANCH: pc_d = branch_tgt;
      SEL_JUMP:   pc_d = jump_tgt;
      SEL_JR:     pc_d = bus.D_RD1;
      default:    pc_d = seq_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.F_PC = pc_q;
  // Delay-slot flag follows decode directly, so it is unaffected by stall.
  assign bus.F_BD = is_branch_instr || is_jump_instr || is_jr_instr;

`ifdef FETCH_ADEL_CHECK_EN
  assign bus.F_ExcAdEL = (pc_q[1:0] != 2'b00) ||
                         (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFC);
`else
  assign bus.F_ExcAdEL = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a priority-rule PC model checked every
// negedge, plus literal expectations at each scenario step.
module tb_fetch_pc_unit;

  localparam logic [9:0] T_NONE = 10'h000;
  localparam logic [9:0] T_BEQ  = 10'h001;
  localparam logic [9:0] T_BNE  = 10'h002;
  localparam logic [9:0] T_J    = 10'h004;
  localparam logic [9:0] T_JAL  = 10'h008;
  localparam logic [9:0] T_JR   = 10'h010;
  localparam logic [9:0] T_ERET = 10'h020;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] off;
    off = 32'($signed(bus.D_imm16)) * 32'd4;
    if (bus.req) return 32'h0000_4180;
    if (bus.D_inStrType == T_ERET) return bus.EPC;
    if (bus.stall) return pc;
    if ((bus.D_inStrType == T_BEQ || bus.D_inStrType == T_BNE) && bus.isBranch)
      return bus.D_PC + 32'd4 + off;
    if (bus.D_inStrType == T_J || bus.D_inStrType == T_JAL)
      return (bus.D_PC & 32'hF000_0000) | (32'(bus.D_index26) * 32'd4);
    if (bus.D_inStrType == T_JR) return bus.D_RD1;
    return pc + 32'd4;
  endfunction

  function automatic logic model_bd();
    return bus.D_inStrType inside {T_BEQ, T_BNE, T_J, T_JAL, T_JR};
  endfunction

  function automatic logic model_adel(input logic [31:0] pc);
`ifdef FETCH_ADEL_CHECK_EN
    return (pc % 4 != 0) || !(pc >= 32'h3000 && pc <= 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_pc = 32'h0000_3000;
    else       m_pc = model_next(m_pc);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_F_PC", bus.F_PC, m_pc);
      chk("cmp_F_BD", {31'd0, bus.F_BD}, {31'd0, model_bd()});
      chk("cmp_F_ExcAdEL", {31'd0, bus.F_ExcAdEL}, {31'd0, model_adel(m_pc)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [9:0] t, input logic [31:0] dpc, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rd1, input logic br);
    bus.D_inStrType = t;
    bus.D_PC        = dpc;
    bus.D_imm16     = imm;
    bus.D_index26   = idx;
    bus.D_RD1       = rd1;
    bus.isBranch    = br;
  endtask

  logic adel_exp_1;

  initial begin
    bus.stall = 1'b0;
    bus.req   = 1'b0;
    bus.EPC   = 32'd0;
    set_d(T_NONE, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
`ifdef FETCH_ADEL_CHECK_EN
    adel_exp_1 = 1'b1;
`else
    adel_exp_1 = 1'b0;
`endif
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    tick();
    tick();
    chk("reset_pc", bus.F_PC, 32'h0000_3000);
    chk("reset_bd", {31'd0, bus.F_BD}, 32'd0);
    reset = 1'b0;

    // Sequential fetch after reset
    tick(); chk("seq_1", bus.F_PC, 32'h0000_3004);
    tick(); chk("seq_2", bus.F_PC, 32'h0000_3008);
    tick(); chk("seq_3", bus.F_PC, 32'h0000_300C);

    // Taken beq backwards
    set_d(T_BEQ, 32'h0000_3010, 16'hFFFC, 26'd0, 32'd0, 1'b1);
    #1 chk("beq_bd", {31'd0, bus.F_BD}, 32'd1);
    tick(); chk("beq_taken", bus.F_PC, 32'h0000_3004);

    // Not-taken bne falls through
    set_d(T_BNE, 32'h0000_3000, 16'h0040, 26'd0, 32'd0, 1'b0);
    tick(); chk("bne_not_taken", bus.F_PC, 32'h0000_3008);

    // j and jal keep D_PC[31:28]
    set_d(T_J, 32'h0000_3008, 16'd0, 26'h0000C10, 32'd0, 1'b0);
    tick(); chk("j_target", bus.F_PC, 32'h0000_3040);
    set_d(T_JAL, 32'hA000_0000, 16'd0, 26'h0000C00, 32'd0, 1'b0);
    tick(); chk("jal_target", bus.F_PC, 32'hA000_3000);
    chk("jal_adel", {31'd0, bus.F_ExcAdEL}, {31'd0, adel_exp_1});
    set_d(T_JR, 32'd0, 16'd0, 26'd0, 32'h0000_3020, 1'b0);
    tick(); chk("jr_target", bus.F_PC, 32'h0000_3020);

    // Stall holds PC even with a taken branch in decode
    bus.stall = 1'b1;
    set_d(T_BNE, 32'h0000_3100, 16'h0010, 26'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", bus.F_PC, 32'h0000_3020);
      chk("stall_bd", {31'd0, bus.F_BD}, 32'd1);
    end
    bus.stall = 1'b0;
    set_d(T_NONE, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    tick(); chk("stall_release", bus.F_PC, 32'h0000_3024);

    // req beats stall and a taken bne
    bus.req = 1'b1;
    bus.stall = 1'b1;
    set_d(T_BNE, 32'h0000_3024, 16'h0008, 26'd0, 32'd0, 1'b1);
    tick(); chk("exc_priority", bus.F_PC, 32'h0000_4180);
    bus.req = 1'b0;

    // eret beats stall
    bus.EPC = 32'h0000_3040;
    set_d(T_ERET, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    tick(); chk("eret_target", bus.F_PC, 32'h0000_3040);
    bus.stall = 1'b0;

    // Misaligned jr target
    set_d(T_JR, 32'd0, 16'd0, 26'd0, 32'h0000_3001, 1'b0);
    tick(); chk("jr_misaligned", bus.F_PC, 32'h0000_3001);
    chk("jr_adel", {31'd0, bus.F_ExcAdEL}, {31'd0, adel_exp_1});

    // Branch target wraps modulo 2^32
    set_d(T_BEQ, 32'hFFFF_FFF8, 16'h0001, 26'd0, 32'd0, 1'b1);
    tick(); chk("branch_wrap", bus.F_PC, 32'h0000_0000);
    set_d(T_JR, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFFC, 1'b0);
    tick(); chk("jr_top", bus.F_PC, 32'hFFFF_FFFC);
    set_d(T_NONE, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    tick(); chk("seq_wrap", bus.F_PC, 32'h0000_0000);

    // Asynchronous reset mid-stall with pending redirect
    set_d(T_JR, 32'd0, 16'd0, 26'd0, 32'h0000_3100, 1'b0);
    tick(); chk("jr_3100", bus.F_PC, 32'h0000_3100);
    bus.stall = 1'b1;
    set_d(T_BEQ, 32'h0000_3100, 16'h0020, 26'd0, 32'd0, 1'b1);
    tick(); chk("pre_reset_hold", bus.F_PC, 32'h0000_3100);
    #1 reset = 1'b1;
    #1 chk("async_reset", bus.F_PC, 32'h0000_3000);
    bus.req = 1'b1;
    tick(); chk("reset_ignores_req", bus.F_PC, 32'h0000_3000);
    reset = 1'b0;
    bus.req = 1'b0;
    bus.stall = 1'b0;
    set_d(T_NONE, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    tick(); chk("post_reset_seq", bus.F_PC, 32'h0000_3004);
    tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have `clk`: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have `reset`: input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have `stall`: input, 1 bit, hazard-unit stall; freezes the PC.
REQ-004 SHALL have `isBranch`: input, 1 bit, decode-stage comparator result.
REQ-005 SHALL have `D_inStrType`: input, 10 bits, decode-stage instruction type, encoded by the InStrType.v macros.
REQ-006 SHALL have `D_PC`: input, 32 bits, PC of the decode-stage instruction.
REQ-007 SHALL have `D_imm16`: input, 16 bits, branch offset field.
REQ-008 SHALL have `D_index26`: input, 26 bits, j/jal index field.
REQ-009 SHALL have `D_RD1`: input, 32 bits, forwarded rs value (jr target).
REQ-010 SHALL have `req`: input, 1 bit, CP0 exception/interrupt request.
REQ-011 SHALL have `EPC`: input, 32 bits, CP0 exception return address.
REQ-012 SHALL have `F_PC`: output, 32 bits, current fetch address (registered).
REQ-013 SHALL have `F_BD`: output, 1 bit, high when the F_PC instruction is a delay slot.
REQ-014 SHALL have `F_ExcAdEL`: output, 1 bit, fetch address error flag.

Function
REQ-015 SHALL load the PC register on each rising `clk` with the next-PC value selected by REQ-016.
REQ-016 SHALL select next-PC by priority, highest first:
- `req` -> 0x0000_4180.
- D_inStrType==`eret` -> EPC.
- `stall` -> hold PC.
- `beq`/`bne` with isBranch=1 -> D_PC+4+(sext(D_imm16)<<2).
- `j`/`jal` -> {D_PC[31:28],D_index26,2'b00}.
- `jr` -> D_RD1.
- otherwise -> PC+4.
REQ-017 SHALL compute all targets modulo 2^32; wrap-around is not an error.
REQ-018 SHALL give a not-taken `beq`/`bne` (isBranch=0) a next-PC of PC+4; the delay slot is already in F.
REQ-019 SHALL override `stall` with `req` and `eret` in the same cycle; the PC redirects anyway.
REQ-020 SHALL drive F_BD combinationally: 1 when D_inStrType is `beq`, `bne`, `j`, `jal` or `jr`, regardless of `stall`; else 0.
REQ-021 SHALL hold F_PC and F_BD stable for every stalled cycle without `req` or `eret`.
REQ-022 SHALL make `req` take effect one edge after assertion; a branch decision in the same cycle is discarded.
REQ-023 SHALL give redirect latency of exactly one clock edge for all redirects; there are no bubbles inside this block.

Reset
REQ-024 SHALL set F_PC to 0x0000_3000 immediately on `reset`=1, independent of `clk`.
REQ-025 SHALL hold F_PC at 0x0000_3000 while `reset` is high, ignoring `req`, `stall` and all redirects.
REQ-026 SHALL perform its first update at the first rising edge after `reset` falls (normally to 0x0000_3004).
REQ-027 SHALL, when `reset` asserts mid-stall or mid-redirect, abandon the pending target; no state survives.

Configuration
REQ-028 SHALL gate fetch address checking with the macro FETCH_ADEL_CHECK_EN.
REQ-029 SHALL, when FETCH_ADEL_CHECK_EN is defined, drive F_ExcAdEL=1 combinationally when F_PC[1:0]!=0 or F_PC is outside 0x0000_3000..0x0000_6FFC inclusive.
REQ-030 SHALL, when FETCH_ADEL_CHECK_EN is undefined, tie F_ExcAdEL to 0 and include no checking logic.
REQ-031 SHALL keep PC sequencing identical with or without FETCH_ADEL_CHECK_EN; the flag never alters next-PC.

Verification
REQ-032 SHALL verify reset and sequential fetch: reset pulse, then 3 edges with no redirect -> F_PC 0x3000, 0x3004, 0x3008, 0x300C.
REQ-033 SHALL verify a taken beq: D_PC=0x3010, D_imm16=0xFFFC, isBranch=1 -> next F_PC=0x3004, F_BD=1 during that cycle.
REQ-034 SHALL verify stall hold: stall=1 for 3 cycles with F_PC=0x3020 -> F_PC stays 0x3020, then 0x3024 after release.
REQ-035 SHALL verify exception priority: req=1, stall=1, taken bne, all in the same cycle -> next F_PC=0x4180.
REQ-036 SHALL verify eret and jr:
- eret, EPC=0x3040 -> next F_PC=0x3040.
- jr, D_RD1=0x3001, FETCH_ADEL_CHECK_EN defined -> F_PC=0x3001 and F_ExcAdEL=1.
- same jr with the macro undefined -> F_ExcAdEL=0.
REQ-037 SHALL verify asynchronous reset: reset asserted between edges mid-stall -> F_PC becomes 0x3000 before the next `clk` edge.
